// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM state
// encoding, the response flag bundle and the signed-overflow rule.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b10;
  localparam logic [1:0] OP_NEG  = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic a_gt;
    logic b_gt;
    logic eq;
  } rsp_flags_t;

  // Signed overflow from operand/result sign bits. Negate and the reserved
  // opcode never report overflow.
  function automatic logic calc_ovf(input logic [1:0] op, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    logic ovf;
    ovf = 1'b0;
    case (op)
      OP_ADD:  ovf = (a_msb == b_msb) && (r_msb != a_msb);
      OP_SUB:  ovf = (a_msb != b_msb) && (r_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// pointer holder wins, and the pointer moves to the loser once accepted.
module rr_arb2 #(
  parameter bit PRIO_RST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q, ptr_d;

  // Pick the winner and the pointer value to use after an accept.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    gnt_id_o = 1'b0;
    gnt_o    = 2'b00;
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ptr_q;
      default: gnt_id_o = 1'b0;
    endcase
    if (|req_i) gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    ptr_d = accept_i ? ~gnt_id_o : ptr_q;
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) ptr_q <= PRIO_RST;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_req_sched.sv
// Two-requester scheduler for one shared 8-bit arithmetic unit: grant,
// register operands, drive the unit for one cycle, then hold the captured
// result and flags until the consumer takes them.
module alu_req_sched
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit PRIO_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_a_gt,
  output logic             rsp_b_gt,
  output logic             rsp_eq,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_a_bigger,
  input  logic             alu_b_bigger,
  input  logic             alu_eq,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  rsp_flags_t       rsp_flags_q, rsp_flags_d;

  logic       in_idle;
  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       accept;

  // Requests are only visible to the arbiter in IDLE, so ready (and the
  // pointer update) can never fire while an operation is in flight.
  assign in_idle = (state_q == IDLE);
  assign arb_req = in_idle ? {req1_valid, req0_valid} : 2'b00;
  assign accept  = |gnt;

  rr_arb2 #(.PRIO_RST(PRIO_RST)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (arb_req),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Next-state logic: grant/latch in IDLE, capture in EXEC, drain in RESP.
  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = gnt_id ? req1_a  : req0_a;
          opb_d   = gnt_id ? req1_b  : req0_b;
          op_d    = gnt_id ? req1_op : req0_op;
          id_d    = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d       = 1'b1;
        rsp_id_d          = id_q;
        rsp_result_d      = alu_result;
        rsp_flags_d.carry = alu_carry;
        rsp_flags_d.zero  = (alu_result == '0);
        rsp_flags_d.ovf   = calc_ovf(op_q, opa_q[WIDTH-1], opb_q[WIDTH-1],
                                     alu_result[WIDTH-1]);
        rsp_flags_d.a_gt  = alu_a_bigger;
        rsp_flags_d.b_gt  = alu_b_bigger;
        rsp_flags_d.eq    = alu_eq;
        state_d           = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= 2'b00;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // The operand register only changes on a grant, so the unit's inputs
  // switch on entry to EXEC and hold their last values otherwise.
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_op     = op_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_flags_q.carry;
  assign rsp_zero   = rsp_flags_q.zero;
  assign rsp_ovf    = rsp_flags_q.ovf;
  assign rsp_a_gt   = rsp_flags_q.a_gt;
  assign rsp_b_gt   = rsp_flags_q.b_gt;
  assign rsp_eq     = rsp_flags_q.eq;
  assign busy       = !in_idle;

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched with a behavioural model of the external
// arithmetic unit. Inputs change 2 time units after a rising edge; outputs
// are sampled 3 units after the edge.
module tb_alu_req_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_ovf, rsp_a_gt, rsp_b_gt, rsp_eq;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic       alu_carry, alu_a_bigger, alu_b_bigger, alu_eq;
  logic       busy;
  logic [8:0] m_sum;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_req_sched #(.WIDTH(8), .PRIO_RST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_a_gt(rsp_a_gt), .rsp_b_gt(rsp_b_gt),
    .rsp_eq(rsp_eq),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_a_bigger(alu_a_bigger),
    .alu_b_bigger(alu_b_bigger), .alu_eq(alu_eq),
    .busy(busy)
  );

  // External shared arithmetic unit.
  always_comb begin
    m_sum = 9'd0;
    case (alu_op)
      2'b00:   m_sum = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   m_sum = {1'b0, alu_a} - {1'b0, alu_b};
      2'b11:   m_sum = {1'b0, ~alu_b} + 9'd1;
      default: m_sum = 9'd0;
    endcase
    alu_result   = m_sum[7:0];
    alu_carry    = m_sum[8];
    alu_a_bigger = alu_a > alu_b;
    alu_b_bigger = alu_b > alu_a;
    alu_eq       = alu_a == alu_b;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Issue one op from a single requester and collect the response.
  // fl = {id, carry, zero, ovf, a_gt, b_gt, eq}; lat = -1 on timeout.
  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, output int lat,
                        output logic [7:0] res, output logic [6:0] fl);
    logic got;
    int   n;
    rsp_ready = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    got = 1'b0; n = 0;
    while (!got && n < 8) begin
      #1; got = id ? req1_ready : req0_ready;
      step(); n++;
    end
    // Disturb the requester's inputs after the handshake.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req0_op = ~op;
    req1_a = ~a; req1_b = ~b; req1_op = ~op;
    lat = -1; res = 8'h00; fl = 7'h00;
    if (got) begin
      n = 1;
      #1;
      while (!rsp_valid && n < 8) begin step(); #1; n++; end
      if (rsp_valid) begin
        lat = n;
        res = rsp_result;
        fl  = {rsp_id, rsp_carry, rsp_zero, rsp_ovf, rsp_a_gt, rsp_b_gt, rsp_eq};
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'b00;
    req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'b00;
    step(); step();
    rst = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    vectors++;
    if ({rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_a_gt, rsp_b_gt, rsp_eq} !== 15'h0) begin
      miscompares++; $display("FAIL reset_rsp: got id=%b res=%h flags=%b required all 0", rsp_id,
                              rsp_result, {rsp_carry, rsp_zero, rsp_ovf, rsp_a_gt, rsp_b_gt, rsp_eq});
    end
    vectors++;
    if ({alu_a, alu_b, alu_op} !== 18'h0) begin
      miscompares++; $display("FAIL reset_alu: got a=%h b=%h op=%b required 0", alu_a, alu_b, alu_op);
    end
    step();
  endtask

  task automatic test_add;
    int lat; logic [7:0] res; logic [6:0] fl;
    run_op(1'b0, 8'h7F, 8'h01, 2'b00, lat, res, fl);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL add_latency: got %0d required 2", lat); end
    vectors++;
    if (res !== 8'h80) begin miscompares++; $display("FAIL add_result: got %h required 80", res); end
    vectors++;
    if (fl !== 7'b0001100) begin miscompares++; $display("FAIL add_flags: got %b required 0001100", fl); end
    #1;
    vectors++;
    if (alu_a !== 8'h7F || alu_b !== 8'h01 || alu_op !== 2'b00) begin
      miscompares++; $display("FAIL alu_hold: got a=%h b=%h op=%b required 7f 01 00", alu_a, alu_b, alu_op);
    end
    step();
    run_op(1'b0, 8'hFF, 8'h01, 2'b00, lat, res, fl);
    vectors++;
    if (res !== 8'h00 || fl !== 7'b0110100) begin
      miscompares++; $display("FAIL add_wrap: got res=%h fl=%b required 00 0110100", res, fl);
    end
  endtask

  task automatic test_sub;
    int lat; logic [7:0] res; logic [6:0] fl;
    run_op(1'b1, 8'h05, 8'h07, 2'b01, lat, res, fl);
    vectors++;
    if (lat !== 2 || res !== 8'hFE || fl !== 7'b1100010) begin
      miscompares++; $display("FAIL sub_borrow: got lat=%0d res=%h fl=%b required 2 fe 1100010", lat, res, fl);
    end
    run_op(1'b1, 8'h80, 8'h01, 2'b01, lat, res, fl);
    vectors++;
    if (res !== 8'h7F || fl !== 7'b1001100) begin
      miscompares++; $display("FAIL sub_ovf: got res=%h fl=%b required 7f 1001100", res, fl);
    end
  endtask

  task automatic test_negate_rsvd;
    int lat; logic [7:0] res; logic [6:0] fl;
    run_op(1'b0, 8'h10, 8'h00, 2'b11, lat, res, fl);
    vectors++;
    if (res !== 8'h00 || fl !== 7'b0110100) begin
      miscompares++; $display("FAIL neg_zero: got res=%h fl=%b required 00 0110100", res, fl);
    end
    run_op(1'b0, 8'h10, 8'h01, 2'b11, lat, res, fl);
    vectors++;
    if (res !== 8'hFF || fl !== 7'b0000100) begin
      miscompares++; $display("FAIL neg_one: got res=%h fl=%b required ff 0000100", res, fl);
    end
    run_op(1'b1, 8'h03, 8'h03, 2'b10, lat, res, fl);
    vectors++;
    if (lat !== 2 || res !== 8'h00 || fl !== 7'b1010001) begin
      miscompares++; $display("FAIL rsvd: got lat=%0d res=%h fl=%b required 2 00 1010001", lat, res, fl);
    end
  endtask

  task automatic test_round_robin;
    int gcnt; int rcnt; int gcyc[4]; logic gid[4];
    do_reset();
    req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00;
    req1_a = 8'h09; req1_b = 8'h04; req1_op = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    gcnt = 0; rcnt = 0;
    for (int c = 0; c < 13; c++) begin
      #1;
      if ((req0_ready || req1_ready) && gcnt < 4) begin
        gcyc[gcnt] = c; gid[gcnt] = req1_ready; gcnt++;
      end
      if (rsp_valid) begin
        vectors++;
        if (rsp_id !== rcnt[0] || rsp_result !== (rcnt[0] ? 8'h05 : 8'h03)) begin
          miscompares++; $display("FAIL rr_rsp%0d: got id=%b res=%h required %b %h", rcnt, rsp_id,
                                  rsp_result, rcnt[0], rcnt[0] ? 8'h05 : 8'h03);
        end
        rcnt++;
      end
      step();
    end
    vectors++;
    if (gcnt !== 4 || rcnt !== 4) begin
      miscompares++; $display("FAIL rr_counts: got grants=%0d rsps=%0d required 4 4", gcnt, rcnt);
    end
    for (int i = 0; i < gcnt; i++) begin
      vectors++;
      if (gcyc[i] !== 3 * i || gid[i] !== i[0]) begin
        miscompares++; $display("FAIL rr_grant%0d: got cycle=%0d id=%b required %0d %b", i, gcyc[i],
                                gid[i], 3 * i, i[0]);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_backpressure;
    logic [7:0] s_res; logic s_id;
    do_reset();
    req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00;
    req1_a = 8'h09; req1_b = 8'h04; req1_op = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_first: got rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    step(); step(); #1;
    s_res = rsp_result; s_id = rsp_id;
    vectors++;
    if (rsp_valid !== 1'b1 || s_id !== 1'b0 || s_res !== 8'h03) begin
      miscompares++; $display("FAIL bp_rsp: got valid=%b id=%b res=%h required 1 0 03", rsp_valid, s_id, s_res);
    end
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_result !== s_res || rsp_id !== s_id || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold%0d: got valid=%b res=%h id=%b busy=%b rdy=%b%b required 1 03 0 1 00",
                                k, rsp_valid, rsp_result, rsp_id, busy, req1_ready, req0_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_same_cycle: got rdy=%b%b required 00", req1_ready, req0_ready);
    end
    step();
    rsp_ready = 1'b0;
    #1;
    vectors++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_next_grant: got rdy=%b%b valid=%b required 10 0", req1_ready,
                              req0_ready, rsp_valid);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    step(); step(); step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic seen;
    for (int ph = 1; ph <= 2; ph++) begin
      do_reset();
      req0_a = 8'h7F; req0_b = 8'h01; req0_op = 2'b00; req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      if (ph == 2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== 8'h00 ||
          {rsp_carry, rsp_zero, rsp_ovf, rsp_a_gt, rsp_b_gt, rsp_eq} !== 6'h0 ||
          alu_a !== 8'h00 || alu_op !== 2'b00) begin
        miscompares++; $display("FAIL mid_reset_ph%0d: got valid=%b busy=%b res=%h alu_a=%h required 0 0 00 00",
                                ph, rsp_valid, busy, rsp_result, alu_a);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      vectors++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        miscompares++; $display("FAIL mid_reset_ptr_ph%0d: got rdy=%b%b required 01", ph, req1_ready, req0_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step(); #1;
        if (rsp_valid) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
        miscompares++; $display("FAIL mid_reset_drop_ph%0d: got rsp_valid=1 required 0", ph);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_negate_rsvd();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
